// File: rtl/f1_pkg.sv
// Shared types and LFSR constants for the F1 start-light sequencer.
package f1_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FILL,
      HOLD,
      GO,
      FAULT
   } f1_state_t;

   localparam int unsigned     LFSR_W    = 7;
   // x^7 + x^6 + 1: feedback from bits 6 and 5
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 7'h60;
   localparam logic [LFSR_W-1:0] LFSR_SEED = 7'h01;

endpackage

// File: rtl/f1_start_seq_if.sv
// Trigger/react inputs and lamp/reaction outputs of the start-light sequencer.
interface f1_start_seq_if #(
   parameter int N_LIGHTS = 8,
   parameter int RT_W     = 16
);
   logic                trigger;
   logic                react;
   logic [N_LIGHTS-1:0] out;
   logic                busy;
   logic                jump_start;
   logic                react_valid;
   logic [RT_W-1:0]     react_time;

   modport master (
      output trigger, react,
      input  out, busy, jump_start, react_valid, react_time
   );

   modport slave (
      input  trigger, react,
      output out, busy, jump_start, react_valid, react_time
   );
endinterface

// File: rtl/f1_lfsr.sv
// Free-running 7-bit Fibonacci LFSR; never leaves the non-zero cycle of 127 states.
module f1_lfsr
   import f1_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   output logic [LFSR_W-1:0] value
);

   always_ff @(posedge clk) begin
      if (rst) begin
         value <= LFSR_SEED;
      end else begin
         value <= {value[LFSR_W-2:0], ^(value & LFSR_TAPS)};
      end
   end

endmodule

// File: rtl/f1_start_seq.sv
// F1 start-light sequencer: fill lamps, random hold, go, optional reaction timing.
// Reaction timer and jump-start detection are built only with F1_REACTION_TIMER_EN.
module f1_start_seq
   import f1_pkg::*;
#(
   parameter int N_LIGHTS        = 8,
   parameter int TICK_CYCLES     = 48,
   parameter int HOLD_MIN_CYCLES = 16,
   parameter int RT_W            = 16
) (
   input logic           clk,
   input logic           rst,
   f1_start_seq_if.slave bus
);

   localparam int LIT_W  = $clog2(N_LIGHTS + 1);
   localparam int TICK_W = $clog2(TICK_CYCLES + 1);
   localparam int HOLD_W = $clog2(HOLD_MIN_CYCLES + 128);

   f1_state_t          state, state_n;
   logic [LIT_W-1:0]   lit, lit_n;
   logic [TICK_W-1:0]  step, step_n;
   logic [HOLD_W-1:0]  hold_cnt, hold_n;
   logic [LFSR_W-1:0]  lfsr;
   logic               react_en;

   f1_lfsr u_lfsr (
      .clk   (clk),
      .rst   (rst),
      .value (lfsr)
   );

`ifdef F1_REACTION_TIMER_EN
   // Count value one short of all-ones: the next increment saturates and ends GO.
   localparam logic [RT_W-1:0] RT_LAST = {{(RT_W-1){1'b1}}, 1'b0};

   logic [RT_W-1:0] rcnt, rcnt_n;
   logic [RT_W-1:0] rt, rt_n;
   logic            rv, rv_n;

   assign react_en        = bus.react;
   assign bus.jump_start  = (state == FAULT);
   assign bus.react_valid = rv;
   assign bus.react_time  = rt;
`else
   logic unused_react;

   assign unused_react    = bus.react;
   assign react_en        = 1'b0;
   assign bus.jump_start  = 1'b0;
   assign bus.react_valid = 1'b0;
   assign bus.react_time  = '0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         lit      <= '0;
         step     <= '0;
         hold_cnt <= '0;
`ifdef F1_REACTION_TIMER_EN
         rcnt     <= '0;
         rt       <= '0;
         rv       <= 1'b0;
`endif
      end else begin
         state    <= state_n;
         lit      <= lit_n;
         step     <= step_n;
         hold_cnt <= hold_n;
`ifdef F1_REACTION_TIMER_EN
         rcnt     <= rcnt_n;
         rt       <= rt_n;
         rv       <= rv_n;
`endif
      end
   end

   always_comb begin
      state_n = state;
      lit_n   = lit;
      step_n  = step;
      hold_n  = hold_cnt;
`ifdef F1_REACTION_TIMER_EN
      rcnt_n  = rcnt;
      rt_n    = rt;
      rv_n    = 1'b0;
`endif
      unique case (state)
         IDLE: begin
            if (bus.trigger) begin
               state_n = FILL;
               lit_n   = LIT_W'(1);
               step_n  = '0;
            end
         end
         FILL: begin
            if (react_en) begin
               state_n = FAULT;
            end else if (step == TICK_W'(TICK_CYCLES - 1)) begin
               step_n = '0;
               if (lit == LIT_W'(N_LIGHTS)) begin
                  state_n = HOLD;
                  hold_n  = HOLD_W'(HOLD_MIN_CYCLES - 1) + HOLD_W'(lfsr);
               end else begin
                  lit_n = lit + LIT_W'(1);
               end
            end else begin
               step_n = step + TICK_W'(1);
            end
         end
         HOLD: begin
            if (react_en) begin
               state_n = FAULT;
            end else if (hold_cnt == '0) begin
               state_n = GO;
`ifdef F1_REACTION_TIMER_EN
               rcnt_n  = '0;
`endif
            end else begin
               hold_n = hold_cnt - HOLD_W'(1);
            end
         end
         GO: begin
`ifdef F1_REACTION_TIMER_EN
            if (bus.react) begin
               state_n = IDLE;
               rt_n    = rcnt;
               rv_n    = 1'b1;
            end else if (rcnt == RT_LAST) begin
               state_n = IDLE;
               rt_n    = '1;
               rv_n    = 1'b1;
            end else begin
               rcnt_n = rcnt + RT_W'(1);
            end
`else
            state_n = IDLE;
`endif
         end
         FAULT: begin
            if (bus.trigger) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      bus.out = '0;
      for (int unsigned i = 0; i < N_LIGHTS; i++) begin
         case (state)
            FILL:        bus.out[i] = (i < 32'(lit));
            HOLD, FAULT: bus.out[i] = 1'b1;
            default:     bus.out[i] = 1'b0;
         endcase
      end
   end

   assign bus.busy = (state != IDLE);

endmodule

// File: tb/tb_f1_start_seq.sv
// Bench for f1_start_seq: timeline model compared every cycle, directed then random stimulus.
// Follows F1_REACTION_TIMER_EN the same way the design does.
module tb_f1_start_seq;

   localparam int N     = 4;
   localparam int T     = 3;
   localparam int HMIN  = 5;
   localparam int RTW   = 4;
   localparam int NT    = N * T;
   localparam int RTMAX = (1 << RTW) - 1;
`ifdef F1_REACTION_TIMER_EN
   localparam bit TIMER = 1'b1;
`else
   localparam bit TIMER = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   f1_start_seq_if #(.N_LIGHTS(N), .RT_W(RTW)) bus ();

   f1_start_seq #(
      .N_LIGHTS        (N),
      .TICK_CYCLES     (T),
      .HOLD_MIN_CYCLES (HMIN),
      .RT_W            (RTW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: 0 idle, 1 fill, 2 hold, 3 go, 4 fault; age counts cycles since trigger.
   int         m_mode = 0, m_age = 0, m_hold_len = 0, m_g = 0, m_rt = 0;
   bit         m_rv = 1'b0, cmp_en = 1'b0;
   logic [6:0] m_lfsr = 7'h01, lf_pre;

   always @(posedge clk) begin
      if (rst) begin
         m_mode = 0; m_rt = 0; m_rv = 1'b0; m_lfsr = 7'h01; cmp_en = 1'b1;
      end else begin
         lf_pre = m_lfsr;
         m_lfsr = {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
         m_rv   = 1'b0;
         case (m_mode)
            0: if (bus.trigger) begin m_mode = 1; m_age = 0; end
            1, 2: begin
               if (TIMER && bus.react) m_mode = 4;
               else if (m_age == NT - 1) begin
                  m_hold_len = HMIN + int'(lf_pre); m_mode = 2; m_age++;
               end else if (m_mode == 2 && m_age == NT + m_hold_len - 1) begin
                  m_mode = 3; m_g = 0;
               end else m_age++;
            end
            3: begin
               if (!TIMER) m_mode = 0;
               else if (bus.react) begin m_rt = m_g; m_rv = 1'b1; m_mode = 0; end
               else if (m_g == RTMAX - 1) begin m_rt = RTMAX; m_rv = 1'b1; m_mode = 0; end
               else m_g++;
            end
            4: if (bus.trigger) m_mode = 0;
            default: m_mode = 0;
         endcase
      end
   end

   function automatic int exp_out();
      if (m_mode == 1) return (1 << (m_age / T + 1)) - 1;
      if (m_mode == 2 || m_mode == 4) return (1 << N) - 1;
      return 0;
   endfunction

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("out", int'(bus.out), exp_out());
         chk("busy", int'(bus.busy), int'(m_mode != 0));
         chk("jump_start", int'(bus.jump_start), int'(m_mode == 4));
         chk("react_valid", int'(bus.react_valid), int'(m_rv));
         chk("react_time", int'(bus.react_time), m_rt);
      end
   end

   task automatic wait_mode(input int m, input int budget);
      int n = 0;
      while (m_mode != m && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (m_mode != m) chk("timeout_wait_mode", m_mode, m);
   endtask

   task automatic pulse_trigger();
      bus.trigger = 1'b1;
      @(negedge clk);
      bus.trigger = 1'b0;
   endtask

   logic [3:0] exp_fill [4] = '{4'h1, 4'h3, 4'h7, 4'hF};

   initial begin
      bus.trigger = 1'b0;
      bus.react   = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_out", int'(bus.out), 0);
      chk("reset_busy", int'(bus.busy), 0);
      chk("reset_react_time", int'(bus.react_time), 0);

      // First sequence straight out of reset: LFSR index 12 (7'h61) sets the hold.
      rst = 1'b0;
      pulse_trigger();
      for (int k = 0; k < NT; k++) begin
         chk("fill_out", int'(bus.out), int'(exp_fill[k / T]));
         @(negedge clk);
      end
      chk("hold_out", int'(bus.out), 15);
      chk("lfsr_hold_len", m_hold_len, HMIN + 97);
      wait_mode(3, 200);
      chk("go_out", int'(bus.out), 0);
      chk("go_busy", int'(bus.busy), 1);
      repeat (10) @(negedge clk);
      bus.react = 1'b1;
      @(negedge clk);
      bus.react = 1'b0;
`ifdef F1_REACTION_TIMER_EN
      chk("react10_valid", int'(bus.react_valid), 1);
      chk("react10_time", int'(bus.react_time), 10);
`endif
      chk("react10_busy", int'(bus.busy), 0);
      @(negedge clk);

      // Jump start while out=3.
      pulse_trigger();
      repeat (T) @(negedge clk);
      bus.react = 1'b1;
      @(negedge clk);
      bus.react = 1'b0;
`ifdef F1_REACTION_TIMER_EN
      chk("fault_out", int'(bus.out), 15);
      chk("fault_jump", int'(bus.jump_start), 1);
      repeat (3) @(negedge clk);
      pulse_trigger();
      chk("fault_clear_jump", int'(bus.jump_start), 0);
      chk("fault_clear_busy", int'(bus.busy), 0);
      chk("fault_keep_time", int'(bus.react_time), 10);
`else
      chk("noflt_jump", int'(bus.jump_start), 0);
      wait_mode(0, 400);
`endif
      @(negedge clk);

      // No reaction: counter saturates.
      pulse_trigger();
      wait_mode(3, 400);
      wait_mode(0, 100);
`ifdef F1_REACTION_TIMER_EN
      chk("sat_valid", int'(bus.react_valid), 1);
      chk("sat_time", int'(bus.react_time), 15);
`endif
      chk("sat_busy", int'(bus.busy), 0);

      // Reset during HOLD.
      pulse_trigger();
      wait_mode(2, 100);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_hold_out", int'(bus.out), 0);
      chk("rst_hold_busy", int'(bus.busy), 0);
      chk("rst_hold_time", int'(bus.react_time), 0);
      pulse_trigger();
      chk("restart_out", int'(bus.out), 1);
      wait_mode(0, 400);

`ifndef F1_REACTION_TIMER_EN
      // React held high all the way through a sequence.
      bus.react = 1'b1;
      pulse_trigger();
      wait_mode(3, 400);
      @(negedge clk);
      chk("react_held_go_len", int'(bus.busy), 0);
      bus.react = 1'b0;
`endif

      for (int c = 0; c < 8000; c++) begin
         bus.trigger = ($urandom_range(0, 7) == 0);
         bus.react   = (m_mode == 3) ? ($urandom_range(0, 9) == 0)
                                     : ($urandom_range(0, 59) == 0);
         rst         = ($urandom_range(0, 999) == 0);
         @(negedge clk);
      end
      bus.trigger = 1'b0;
      bus.react   = 1'b0;
      rst         = 1'b0;
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/f1_start_seq.md
# f1_start_seq

Parametrised Formula-1 start-light sequencer: on a trigger it lights N lamps one per step, holds all lamps lit for a pseudo-random interval, then extinguishes them. It optionally measures driver reaction time and flags jump starts. It replaces the fixed 8-lamp sequencer in the lights datapath, and drives the lamp bank and reaction-time display directly. Step timing is internal, so it needs no external tick or delay units.

## Interface
- N_LIGHTS, 8, lamp count; legal range 2..16
- TICK_CYCLES, 48, clock cycles per lamp step; must be ≥1
- HOLD_MIN_CYCLES, 16, fixed part of the all-lit hold; must be ≥1
- RT_W, 16, reaction-time counter width
- clk  in  1  clock; one clock domain only
- rst  in  1  reset, synchronous, active-high
- trigger  in  1  start request; level-sampled each cycle
- react  in  1  driver button; level-sampled each cycle
- out  out  N_LIGHTS  lamp drive; bit i lights lamp i
- busy  out  1  high whenever the state is not IDLE
- jump_start  out  1  high while in FAULT
- react_valid  out  1  one-cycle pulse when react_time updates
- react_time  out  RT_W  last measured reaction, in cycles; holds its value between measurements

## Operation
- States: IDLE, FILL, HOLD, GO, FAULT.
- IDLE:
  - out=0.
  - trigger=1 → FILL, with lit=1 and step counter=0.
  - react is ignored.
- FILL:
  - out = (1<<lit)-1, so lamps fill from the LSB.
  - The step counter counts 0..TICK_CYCLES-1.
  - At wrap, if lit<N_LIGHTS, lit increments.
  - At wrap, if lit==N_LIGHTS → HOLD, with hold counter = HOLD_MIN_CYCLES + lfsr - 1.
- HOLD:
  - out = all ones.
  - The hold counter decrements each cycle; at 0 → GO, with the reaction counter cleared.
- GO (reaction timer compiled in):
  - out=0.
  - The reaction counter increments each cycle and saturates at all-ones.
  - react=1 → IDLE; react_time = current count; react_valid pulses.
  - If the counter reaches all-ones → IDLE; react_time = all-ones; react_valid pulses.
- react=1 in FILL or HOLD → FAULT. react has priority over step wrap or hold expiry in the same cycle.
- FAULT:
  - out = all ones.
  - jump_start=1.
  - react_time is unchanged.
  - trigger=1 → IDLE (clear only; no restart in the same cycle).
- trigger is ignored in FILL, HOLD and GO.
- LFSR:
  - 7-bit Fibonacci, polynomial x^7+x^6+1, seed 7'h01.
  - Advances every cycle, including in IDLE.
  - Sampled at the FILL→HOLD edge, giving values 1..127.
- Width rules: lit is $clog2(N_LIGHTS+1) bits. The hold counter is wide enough for HOLD_MIN_CYCLES+127.

## Timing
- Reset values: out=0, busy=0, jump_start=0, react_valid=0, react_time=0, state=IDLE, LFSR=7'h01.
- rst mid-sequence returns to IDLE on the next edge with all reset values, including react_time.
- All outputs are registered or decoded from registered state only; no input-to-output combinational path.
- trigger is sampled at edge t; out=1 and busy=1 from cycle t+1.
- Each lamp count persists exactly TICK_CYCLES cycles. The full lamp count persists TICK_CYCLES cycles, then HOLD begins.
- HOLD lasts exactly HOLD_MIN_CYCLES + lfsr_sample cycles.
- react sampled in the first GO cycle gives react_time=0. react_valid is high for exactly one cycle, the first IDLE cycle after GO.
- react and trigger are both high in IDLE: go to FILL; react is ignored.

## Configuration
- F1_REACTION_TIMER_EN defined: GO behaves as above, and the jump-start/FAULT path exists.
- F1_REACTION_TIMER_EN undefined:
  - GO lasts one cycle (out=0), then IDLE.
  - react is ignored everywhere; FAULT is unreachable.
  - jump_start, react_valid and react_time are tied to 0.
  - The reaction counter is not synthesised.

## Structure
- Package f1_pkg holds:
  - the state enum typedef f1_state_t;
  - the LFSR width, tap mask and seed constants.
- One sub-module, f1_lfsr: free-running LFSR, clk/rst in, 7-bit value out.
- Everything else lives in f1_start_seq.

## Test plan
Unless noted, parameters are N_LIGHTS=4, TICK_CYCLES=3, HOLD_MIN_CYCLES=5.
- Reset, then one trigger pulse → out = 1,3,7,F, each for 3 cycles. Then F holds for 5+lfsr cycles, where lfsr is the model's LFSR value at the FILL→HOLD edge. Then out=0 and busy=1 in GO.
- react asserted 10 cycles after GO entry → react_valid pulses once; react_time=10; state IDLE; busy=0.
- react asserted while out=3 (in FILL) → FAULT: out=F, jump_start=1. trigger then returns to IDLE with jump_start=0 and react_time unchanged.
- RT_W=4, no react in GO → after 15 cycles react_time=15, react_valid pulses, state IDLE.
- rst asserted during HOLD → next cycle all outputs at reset values. A subsequent trigger restarts with out=1.
- F1_REACTION_TIMER_EN undefined, react held high throughout → the sequence completes; GO lasts 1 cycle; jump_start and react_valid stay 0.
